// File: rtl/wb_regfile_pkg.sv
// Shared types and helpers for the Wishbone register-file responder.
// Contents: FSM state enum and the byte-address to word-index shift helper.
package wb_regfile_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    // Number of low address bits that select a byte within one bus word.
    function automatic int unsigned word_shift(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/wb_byte_merge.sv
// Byte-lane merge of a latched write word into one register word.
// Ports:
//   cur_i    - current register contents
//   wdata_i  - latched write data
//   sel_i    - latched byte enables, one per byte lane
//   merged_c - cur_i with every selected byte replaced by wdata_i (combinational)
module wb_byte_merge #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   cur_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    output logic [DATA_WIDTH-1:0]   merged_c
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

    always_comb begin
        merged_c = cur_i;
        for (int unsigned b = 0; b < NUM_BYTES; b++) begin
            if (sel_i[b]) begin
                merged_c[b*8 +: 8] = wdata_i[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/wb_regfile_slave.sv
// Wishbone classic-cycle responder: byte-writable control registers plus
// read-only status words, one single-cycle termination per accepted transfer.
// Optional feature macro: WB_REGFILE_ERR_EN (unmapped index terminates with err).
// Ports:
//   clk_i, rst_n_i          - clock, asynchronous active-low reset
//   wb_cyc_i/stb_i/we_i     - bus cycle, strobe, write enable
//   wb_addr_i/sel_i/data_i  - byte address, byte enables, write data
//   wb_data_o/ack_o/err_o   - read data and terminations (combinational)
//   status_i                - packed status words, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ctrl_o                  - packed control registers, same packing (registered)
//   wr_pulse_o              - per-register write pulse during the response cycle (registered)
module wb_regfile_slave
    import wb_regfile_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter int unsigned          NUM_RW     = 8,
    parameter int unsigned          NUM_RO     = 4,
    parameter logic [DATA_WIDTH-1:0] RW_RESET  = '0
) (
    input  logic                                             clk_i,
    input  logic                                             rst_n_i,
    input  logic                                             wb_cyc_i,
    input  logic                                             wb_stb_i,
    input  logic                                             wb_we_i,
    input  logic [ADDR_WIDTH-1:0]                            wb_addr_i,
    input  logic [DATA_WIDTH/8-1:0]                          wb_sel_i,
    input  logic [DATA_WIDTH-1:0]                            wb_data_i,
    output logic [DATA_WIDTH-1:0]                            wb_data_o,
    output logic                                             wb_ack_o,
    output logic                                             wb_err_o,
    input  logic [(NUM_RO > 0 ? NUM_RO*DATA_WIDTH : 1)-1:0]  status_i,
    output logic [NUM_RW*DATA_WIDTH-1:0]                     ctrl_o,
    output logic [NUM_RW-1:0]                                wr_pulse_o
);

    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned SHIFT     = word_shift(DATA_WIDTH);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    we_q, we_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   ctrl_q [NUM_RW];
    logic [DATA_WIDTH-1:0]   ctrl_d [NUM_RW];
    logic [DATA_WIDTH-1:0]   merged [NUM_RW];
    logic [NUM_RW-1:0]       wr_pulse_q, wr_pulse_d;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    req;

    assign req = wb_cyc_i & wb_stb_i;

`ifdef WB_REGFILE_ERR_EN
    logic mapped;
    assign mapped = idx_q < ADDR_WIDTH'(NUM_RW + NUM_RO);
`endif

    // Per-register byte merge of the latched write word.
    for (genvar k = 0; k < NUM_RW; k++) begin : g_reg
        wb_byte_merge #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_merge (
            .cur_i    (ctrl_q[k]),
            .wdata_i  (data_q),
            .sel_i    (sel_q),
            .merged_c (merged[k])
        );
        assign ctrl_o[k*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[k];
    end

    assign wr_pulse_o = wr_pulse_q;

    // Read mux over the latched index; unmapped indices read as zero.
    always_comb begin
        rd_word = '0;
        for (int unsigned k = 0; k < NUM_RW; k++) begin
            if (idx_q == ADDR_WIDTH'(k)) begin
                rd_word = ctrl_q[k];
            end
        end
        for (int unsigned k = 0; k < NUM_RO; k++) begin
            if (idx_q == ADDR_WIDTH'(NUM_RW + k)) begin
                rd_word = status_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state, request latch, register commit and bus terminations.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        we_d       = we_q;
        sel_d      = sel_q;
        data_d     = data_q;
        ctrl_d     = ctrl_q;
        wr_pulse_d = '0;
        wb_ack_o   = 1'b0;
        wb_err_o   = 1'b0;
        wb_data_o  = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = RESP;
                    idx_d   = wb_addr_i >> SHIFT;
                    we_d    = wb_we_i;
                    sel_d   = wb_sel_i;
                    data_d  = wb_data_i;
                    // Pulse is registered, so it marks the accepted write request.
                    for (int unsigned k = 0; k < NUM_RW; k++) begin
                        wr_pulse_d[k] = wb_we_i && (idx_d == ADDR_WIDTH'(k));
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                // Master still strobing: terminate; otherwise the transfer is dropped.
                if (req) begin
`ifdef WB_REGFILE_ERR_EN
                    wb_ack_o = mapped;
                    wb_err_o = !mapped;
`else
                    wb_ack_o = 1'b1;
`endif
                    if (!we_q) begin
                        wb_data_o = rd_word;
                    end else begin
                        for (int unsigned k = 0; k < NUM_RW; k++) begin
                            if (idx_q == ADDR_WIDTH'(k)) begin
                                ctrl_d[k] = merged[k];
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            data_q     <= '0;
            wr_pulse_q <= '0;
            for (int unsigned k = 0; k < NUM_RW; k++) begin
                ctrl_q[k] <= RW_RESET;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            wr_pulse_q <= wr_pulse_d;
            ctrl_q     <= ctrl_d;
        end
    end

endmodule

// File: tb/tb_wb_regfile_slave.sv
// Self-checking bench for wb_regfile_slave: transaction-level model plus a
// per-cycle compare process, directed literal checks and random traffic.
module tb_wb_regfile_slave;

    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 32;
    localparam int unsigned NUM_RW = 8;
    localparam int unsigned NUM_RO = 4;
    localparam logic [31:0] RST    = 32'hA5A5_0000;
`ifdef WB_REGFILE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                   clk;
    logic                   rst_n;
    logic                   cyc, stb, we;
    logic [AW-1:0]          addr;
    logic [3:0]             sel;
    logic [DW-1:0]          wdata;
    logic [DW-1:0]          rdata;
    logic                   ack, err;
    logic [NUM_RO*DW-1:0]   status;
    logic [NUM_RW*DW-1:0]   ctrl;
    logic [NUM_RW-1:0]      pulse;

    int total = 0;
    int bad   = 0;

    wb_regfile_slave #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_RW     (NUM_RW),
        .NUM_RO     (NUM_RO),
        .RW_RESET   (RST)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_addr_i  (addr),
        .wb_sel_i   (sel),
        .wb_data_i  (wdata),
        .wb_data_o  (rdata),
        .wb_ack_o   (ack),
        .wb_err_o   (err),
        .status_i   (status),
        .ctrl_o     (ctrl),
        .wr_pulse_o (pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A transfer is accepted on any edge that sees a request while no transfer
    // is pending; it is answered in the following cycle if the request persists.
    logic [31:0] m_ctrl [NUM_RW];
    bit          pend;
    logic [31:0] p_idx;
    bit          p_we;
    logic [3:0]  p_sel;
    logic [31:0] p_data;

    function automatic logic [31:0] m_word(input logic [31:0] idx);
        if (idx < 32'(NUM_RW)) return m_ctrl[idx[2:0]];
        if (idx < 32'(NUM_RW + NUM_RO)) return status[(idx - 32'(NUM_RW)) * 32 +: 32];
        return 32'h0;
    endfunction

    task automatic m_reset();
        pend = 1'b0;
        for (int i = 0; i < NUM_RW; i++) m_ctrl[i] = RST;
    endtask

    always @(negedge rst_n) m_reset();

    always @(posedge clk) begin
        if (!rst_n) begin
            m_reset();
        end else if (pend) begin
            if ((cyc & stb) && p_we && p_idx < 32'(NUM_RW))
                for (int b = 0; b < 4; b++)
                    if (p_sel[b]) m_ctrl[p_idx[2:0]][b*8 +: 8] = p_data[b*8 +: 8];
            pend = 1'b0;
        end else if (cyc & stb) begin
            pend   = 1'b1;
            p_idx  = addr >> 2;
            p_we   = we;
            p_sel  = sel;
            p_data = wdata;
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic              e_ack, e_err;
        logic [31:0]       e_data;
        logic [NUM_RW-1:0] e_pulse;
        logic [255:0]      e_ctrl;
        bit                mapped;
        e_ack   = 1'b0;
        e_err   = 1'b0;
        e_data  = 32'h0;
        e_pulse = '0;
        mapped  = pend && (p_idx < 32'(NUM_RW + NUM_RO));
        if (pend && (cyc & stb)) begin
            e_ack = mapped || !ERR_EN;
            e_err = !mapped && ERR_EN;
            if (!p_we) e_data = m_word(p_idx);
        end
        if (pend && p_we && p_idx < 32'(NUM_RW)) e_pulse[p_idx[2:0]] = 1'b1;
        for (int i = 0; i < NUM_RW; i++) e_ctrl[i*32 +: 32] = m_ctrl[i];
        chk("ack",   256'(ack),   256'(e_ack));
        chk("err",   256'(err),   256'(e_err));
        chk("rdata", 256'(rdata), 256'(e_data));
        chk("pulse", 256'(pulse), 256'(e_pulse));
        chk("ctrl",  ctrl,        e_ctrl);
    end

    // ---------------- directed driver ----------------
    // Called just after a rising edge; returns just after the edge that ends RESP.
    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit drop,
                        output logic [31:0] rd, output logic o_ack, output logic o_err,
                        output logic [NUM_RW-1:0] o_pulse, output logic [255:0] o_ctrl);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
        @(posedge clk); #1;
        if (drop) begin cyc = 1'b0; stb = 1'b0; end
        @(negedge clk);
        rd = rdata; o_ack = ack; o_err = err; o_pulse = pulse; o_ctrl = ctrl;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    logic [31:0]       r;
    logic              a_o, e_o;
    logic [NUM_RW-1:0] p_o;
    logic [255:0]      c_o;
    logic [255:0]      exp_vec;

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        addr = '0; sel = '0; wdata = '0; status = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl",  ctrl,           {8{RST}});
        chk("rst_ack",   256'(ack),      256'(0));
        chk("rst_err",   256'(err),      256'(0));
        chk("rst_data",  256'(rdata),    256'(0));
        chk("rst_pulse", 256'(pulse),    256'(0));
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-word write, latency and pulse.
        xfer(1, 32'h4, 32'hDEADBEEF, 4'hF, 0, r, a_o, e_o, p_o, c_o);
        chk("wr1_ack",    256'(a_o),        256'(1));
        chk("wr1_pulse",  256'(p_o),        256'(8'b0000_0010));
        chk("wr1_early",  256'(c_o[63:32]), 256'(RST));
        chk("wr1_ctrl",   256'(ctrl[63:32]), 256'(32'hDEADBEEF));
        xfer(0, 32'h4, 32'h0, 4'h0, 0, r, a_o, e_o, p_o, c_o);
        chk("rd1_data",   256'(r),          256'(32'hDEADBEEF));
        chk("rd1_pulse",  256'(p_o),        256'(0));

        // Partial byte write.
        xfer(1, 32'h0, 32'h0, 4'hF, 0, r, a_o, e_o, p_o, c_o);
        xfer(1, 32'h0, 32'h11223344, 4'b0101, 0, r, a_o, e_o, p_o, c_o);
        xfer(0, 32'h1, 32'h0, 4'h0, 0, r, a_o, e_o, p_o, c_o);
        chk("sel_data",   256'(r),          256'(32'h00220044));

        // Status read and ignored status write.
        status[31:0] = 32'h0000CAFE;
        xfer(0, 32'h20, 32'h0, 4'h0, 0, r, a_o, e_o, p_o, c_o);
        chk("st_data",    256'(r),          256'(32'h0000CAFE));
        chk("st_ack",     256'(a_o),        256'(1));
        exp_vec = {{6{RST}}, 32'hDEADBEEF, 32'h00220044};
        xfer(1, 32'h20, 32'h12345678, 4'hF, 0, r, a_o, e_o, p_o, c_o);
        chk("stw_ack",    256'(a_o),        256'(1));
        chk("stw_ctrl",   ctrl,             exp_vec);

        // Unmapped access.
        xfer(0, 32'h40, 32'h0, 4'h0, 0, r, a_o, e_o, p_o, c_o);
        chk("um_ack",     256'(a_o),        256'(!ERR_EN));
        chk("um_err",     256'(e_o),        256'(ERR_EN));
        chk("um_data",    256'(r),          256'(0));
        xfer(1, 32'h40, 32'hFFFFFFFF, 4'hF, 0, r, a_o, e_o, p_o, c_o);
        chk("umw_ctrl",   ctrl,             exp_vec);

        // Master abandons the write during the response cycle.
        xfer(1, 32'h8, 32'h55555555, 4'hF, 1, r, a_o, e_o, p_o, c_o);
        chk("drop_ack",   256'(a_o),        256'(0));
        chk("drop_ctrl",  256'(ctrl[95:64]), 256'(RST));

        // Reset asserted in the middle of the response cycle.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h77777777; sel = 4'hF;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_ack",   256'(ack),        256'(0));
        chk("mrst_pulse", 256'(pulse),      256'(0));
        chk("mrst_ctrl",  ctrl,             {8{RST}});
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mrst_after", 256'(ctrl[95:64]), 256'(RST));

        // Random traffic, including held back-to-back requests.
        for (int c = 0; c < 3000; c++) begin
            cyc   = ($urandom_range(0, 3) != 0);
            stb   = ($urandom_range(0, 3) != 0);
            we    = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 15) == 0) addr = $urandom;
            else addr = (32'($urandom_range(0, 19)) << 2) | 32'($urandom_range(0, 3));
            sel    = 4'($urandom_range(0, 15));
            wdata  = $urandom;
            status = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        cyc = 1'b0; stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
